mac_scheduler: RTL and testbench

Round-robin scheduler that shares one three-operand multiply-accumulate unit (data_out = a*b+c, operands streamed on consecutive validi cycles) between NREQ requesters. Each requester presents a complete (a, b, c) job over a valid/ready handshake. The scheduler serialises the accepted job onto the MAC's validi/data_in stream, captures the MAC result, and returns it tagged with the requester id. It sits directly in front of the existing MAC and is the only driver of the MAC's input port.

---
 rtl/mac_sched_pkg.sv | 27 ++
 rtl/mac_scheduler_rr_arbiter.sv | 39 +++
 rtl/mac_scheduler.sv | 168 ++++++++++++++++
 tb/tb_mac_scheduler.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_sched_pkg.sv
// mac_sched_pkg
// Shared types and constants for the MAC scheduler slice.
//   DEF_NREQ / DEF_W : default requester count and operand width
//   DRAIN_CYCLES     : idle cycles after reset before the first grant
//   state_e          : scheduler FSM states
//   rsp_t            : response record {id, data, err} at the default sizing
package mac_sched_pkg;

  localparam int DEF_NREQ     = 4;
  localparam int DEF_W        = 32;
  localparam int DRAIN_CYCLES = 2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    LOAD_C,
    WAIT
  } state_e;

  typedef struct packed {
    logic [$clog2(DEF_NREQ)-1:0] id;
    logic [DEF_W-1:0]            data;
    logic                        err;
  } rsp_t;

endpackage

// File: rtl/mac_scheduler_rr_arbiter.sv
// rr_arbiter
// Combinational round-robin arbiter. The search starts one position after
// last_grant and wraps from NREQ-1 to 0; the first requesting index wins.
// Ports:
//   req        in  NREQ  request vector
//   en         in  1     grant enable; no grant is produced when low
//   last_grant in  IDW   index of the previous winner
//   gnt        out NREQ  one-hot grant (all zero when nothing wins)
//   gnt_idx    out IDW   encoded index of the winner (0 when nothing wins)
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic            en,
  input  logic [IDW-1:0]  last_grant,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx
);

  logic           found;
  logic [IDW-1:0] k;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    k       = '0;
    for (int i = 1; i <= NREQ; i++) begin
      k = IDW'((int'(last_grant) + i) % NREQ);
      if (en && !found && req[k]) begin
        gnt[k]  = 1'b1;
        gnt_idx = k;
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mac_scheduler.sv
// mac_scheduler
// Shares one streaming multiply-accumulate unit (result = a*b+c, operands
// presented on three consecutive validi cycles) between NREQ requesters.
// A granted job is serialised onto the MAC input, the MAC result is captured
// one cycle after the last operand, and it is returned tagged with the
// requester id through a single-entry response register.
// Ports:
//   clk, rst_n           clock (shared with the MAC), async active-low reset
//   req_valid/a/b/c      per-requester job handshake and operands
//   req_ready            one-hot accept strobe (combinational)
//   rsp_valid/ready      response handshake
//   rsp_id/data/err      result record; err=1 when the MAC gave no valido
//   mac_validi/data_in   operand stream into the MAC
//   mac_valido/data_out  result from the MAC
module mac_scheduler
  import mac_sched_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int W    = DEF_W,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ-1:0][W-1:0]    req_a,
  input  logic [NREQ-1:0][W-1:0]    req_b,
  input  logic [NREQ-1:0][W-1:0]    req_c,
  output logic [NREQ-1:0]           req_ready,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [IDW-1:0]            rsp_id,
  output logic [W-1:0]              rsp_data,
  output logic                      rsp_err,
  output logic                      mac_validi,
  output logic [W-1:0]              mac_data_in,
  input  logic                      mac_valido,
  input  logic [W-1:0]              mac_data_out
);

  state_e         state_q, state_d;
  logic [IDW-1:0] last_q, last_d;
  logic [1:0]     drain_q, drain_d;

  logic [W-1:0]   a_q, b_q, c_q;
  logic [IDW-1:0] id_q;

  logic           rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [W-1:0]   rsp_data_q, rsp_data_d;
  logic           rsp_err_q, rsp_err_d;

  logic            grant_en;
  logic            accept;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx;

  // A grant needs the post-reset flush finished and a response slot that is
  // empty now or being emptied this cycle, so the job can always complete.
  assign grant_en = (state_q == IDLE) && (drain_q == 2'd0) &&
                    (!rsp_valid_q || rsp_ready);

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req        (req_valid),
    .en         (grant_en),
    .last_grant (last_q),
    .gnt        (gnt),
    .gnt_idx    (gnt_idx)
  );

  // gnt only has a bit set where req_valid is high, so a non-zero grant is
  // the completed handshake.
  assign req_ready = gnt;
  assign accept    = |gnt;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    drain_d     = drain_q;
    mac_validi  = 1'b0;
    mac_data_in = '0;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;

    if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (drain_q != 2'd0) begin
          drain_d = drain_q - 2'd1;
        end else if (accept) begin
          last_d  = gnt_idx;
          state_d = LOAD_A;
        end
      end
      LOAD_A: begin
        mac_validi  = 1'b1;
        mac_data_in = a_q;
        state_d     = LOAD_B;
      end
      LOAD_B: begin
        mac_validi  = 1'b1;
        mac_data_in = b_q;
        state_d     = LOAD_C;
      end
      LOAD_C: begin
        mac_validi  = 1'b1;
        mac_data_in = c_q;
        state_d     = WAIT;
      end
      WAIT: begin
        // validi stays low here: that resets the MAC's operand window so the
        // next job cannot reuse this job's b and c.
        rsp_valid_d = 1'b1;
        rsp_id_d    = id_q;
        rsp_data_d  = mac_valido ? mac_data_out : '0;
        rsp_err_d   = !mac_valido;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and response state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= IDW'(NREQ - 1);
      drain_q     <= 2'(DRAIN_CYCLES);
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      drain_q     <= drain_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Job operand latches; only read in LOAD_x/WAIT, which follow an accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q  <= req_a[gnt_idx];
      b_q  <= req_b[gnt_idx];
      c_q  <= req_c[gnt_idx];
      id_q <= gnt_idx;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mac_scheduler.sv
module tb_mac_scheduler;

  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int IDW  = 2;

  logic                   clk;
  logic                   rst_n;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0][W-1:0] req_a, req_b, req_c;
  logic [NREQ-1:0]        req_ready;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [IDW-1:0]         rsp_id;
  logic [W-1:0]           rsp_data;
  logic                   rsp_err;
  logic                   mac_validi;
  logic [W-1:0]           mac_data_in;
  logic                   mac_valido;
  logic [W-1:0]           mac_data_out;

  logic                   fault;

  int n_assert = 0;
  int n_fail   = 0;

  mac_scheduler #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_c        (req_c),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_data     (rsp_data),
    .rsp_err      (rsp_err),
    .mac_validi   (mac_validi),
    .mac_data_in  (mac_data_in),
    .mac_valido   (mac_valido),
    .mac_data_out (mac_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the shared MAC: three consecutive validi samples a, b, c
  // give valido=1 with a*b+c on the following cycle; a low validi clears it.
  logic [1:0]   mcnt = 2'd0;
  logic [W-1:0] m0 = '0, m1 = '0;
  logic         mac_vo_raw = 1'b0;
  logic [W-1:0] mac_do_raw = '0;

  always @(posedge clk) begin
    if (mac_validi) begin
      if (mcnt == 2'd2) begin
        mac_vo_raw <= 1'b1;
        mac_do_raw <= m0 * m1 + mac_data_in;
      end else begin
        mac_vo_raw <= 1'b0;
      end
      m0   <= m1;
      m1   <= mac_data_in;
      mcnt <= (mcnt == 2'd2) ? 2'd2 : mcnt + 2'd1;
    end else begin
      mcnt       <= 2'd0;
      mac_vo_raw <= 1'b0;
    end
  end

  assign mac_valido   = mac_vo_raw & ~fault;
  assign mac_data_out = mac_do_raw;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] c);
    req_valid[r[1:0]] = 1'b1;
    req_a[r[1:0]]     = a;
    req_b[r[1:0]]     = b;
    req_c[r[1:0]]     = c;
  endtask

  task automatic wait_grant(input int r);
    #1;
    for (int i = 0; i < 30 && req_ready == '0; i++) step();
    chk("grant_seen", 64'(req_ready != '0), 64'd1);
    chk("grant_onehot", 64'(req_ready), 64'd1 << r);
  endtask

  // Called just after the accepting edge.
  task automatic finish_job(input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] c, input logic [W-1:0] exp,
                            input logic err);
    chk("validi_a", 64'(mac_validi), 64'd1);
    chk("data_in_a", 64'(mac_data_in), 64'(a));
    step();
    chk("validi_b", 64'(mac_validi), 64'd1);
    chk("data_in_b", 64'(mac_data_in), 64'(b));
    step();
    chk("validi_c", 64'(mac_validi), 64'd1);
    chk("data_in_c", 64'(mac_data_in), 64'(c));
    step();
    chk("validi_wait", 64'(mac_validi), 64'd0);
    chk("rsp_not_yet", 64'(rsp_valid), 64'd0);
    step();
    chk("rsp_valid", 64'(rsp_valid), 64'd1);
    chk("rsp_id", 64'(rsp_id), 64'(r));
    chk("rsp_data", 64'(rsp_data), 64'(exp));
    chk("rsp_err", 64'(rsp_err), 64'(err));
  endtask

  task automatic run_job(input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] c, input logic [W-1:0] exp,
                         input logic err);
    set_req(r, a, b, c);
    wait_grant(r);
    step();
    req_valid[r[1:0]] = 1'b0;
    finish_job(r, a, b, c, exp, err);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_c     = '0;
    rsp_ready = 1'b1;
    fault     = 1'b0;
    #2;
    rst_n = 1'b0;

    // Reset values, with a request already pending
    set_req(2, 32'd3, 32'd5, 32'd7);
    step();
    step();
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    chk("rst_validi", 64'(mac_validi), 64'd0);
    chk("rst_data_in", 64'(mac_data_in), 64'd0);

    // Drain holds off grants for two edges; the third edge accepts
    rst_n = 1'b1;
    chk("drain_0", 64'(req_ready), 64'd0);
    step();
    chk("drain_1", 64'(req_ready), 64'd0);
    step();
    chk("first_grant", 64'(req_ready), 64'b0100);
    step();
    req_valid[2] = 1'b0;
    finish_job(2, 32'd3, 32'd5, 32'd7, 32'd22, 1'b0);

    // Round-robin with all four requesters held valid
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 32'(i + 1), 32'd10, 32'(i));
    for (int k = 0; k < 5; k++) begin
      wait_grant(k % 4);
      step();
      finish_job(k % 4, 32'(k % 4 + 1), 32'd10, 32'(k % 4), 32'(10 * (k % 4 + 1) + k % 4), 1'b0);
    end
    req_valid = '0;

    // Overflow wraps to W bits
    run_job(1, 32'hFFFF_FFFF, 32'd2, 32'd3, 32'h0000_0001, 1'b0);

    // Backpressure: no grant while the response is held, fields stable
    run_job(3, 32'd100, 32'd200, 32'd5, 32'd20005, 1'b0);
    rsp_ready = 1'b0;
    set_req(1, 32'd1, 32'd1, 32'd1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_no_grant", 64'(req_ready), 64'd0);
      chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_rsp_id", 64'(rsp_id), 64'd3);
      chk("bp_rsp_data", 64'(rsp_data), 64'd20005);
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_grant", 64'(req_ready), 64'b0010);
    step();
    req_valid[1] = 1'b0;
    chk("bp_consumed", 64'(rsp_valid), 64'd0);
    finish_job(1, 32'd1, 32'd1, 32'd1, 32'd2, 1'b0);

    // MAC fault, then normal service resumes
    fault = 1'b1;
    run_job(2, 32'd4, 32'd4, 32'd4, 32'd0, 1'b1);
    fault = 1'b0;
    run_job(0, 32'd6, 32'd7, 32'd8, 32'd50, 1'b0);

    // Reset during LOAD_B drops the job
    set_req(3, 32'd9, 32'd9, 32'd9);
    wait_grant(3);
    step();
    req_valid[3] = 1'b0;
    step();
    chk("midjob_in_load_b", 64'(mac_data_in), 64'd9);
    rst_n = 1'b0;
    #1;
    chk("midjob_validi", 64'(mac_validi), 64'd0);
    chk("midjob_data_in", 64'(mac_data_in), 64'd0);
    chk("midjob_rsp_valid", 64'(rsp_valid), 64'd0);
    set_req(0, 32'd2, 32'd3, 32'd4);
    set_req(1, 32'd1, 32'd1, 32'd1);
    set_req(2, 32'd1, 32'd1, 32'd1);
    set_req(3, 32'd1, 32'd1, 32'd1);
    chk("midjob_req_ready", 64'(req_ready), 64'd0);
    step();
    chk("midjob_no_rsp", 64'(rsp_valid), 64'd0);
    rst_n = 1'b1;
    chk("post_rst_drain0", 64'(req_ready), 64'd0);
    step();
    chk("post_rst_drain1", 64'(req_ready), 64'd0);
    chk("post_rst_no_rsp", 64'(rsp_valid), 64'd0);
    step();
    chk("post_rst_rr0", 64'(req_ready), 64'b0001);
    step();
    req_valid = '0;
    finish_job(0, 32'd2, 32'd3, 32'd4, 32'd10, 1'b0);

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
